poly_reg_bank_ctrl: RTL and testbench

Transfer sequencer for the AMNS polynomial register bank. It accepts one command at a time:
- **Load**: read operands A, B, M and M_prime_0 from a single-port operand BRAM into the bank's input shift registers.
- **Store**: write the RES register contents back to the BRAM.

It drives the bank's INPUT select/enable and store-enable strobes, and aligns them with the BRAM read latency. It sits between the top-level MM controller and the `POLY_reg_bank` / operand BRAM pair.

---
 rtl/poly_ctrl_pkg.sv | 35 +++
 rtl/bram_rd_pipe.sv | 52 +++++
 rtl/poly_reg_bank_ctrl.sv | 154 +++++++++++++++
 tb/tb_poly_reg_bank_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_ctrl_pkg.sv
// Shared types and word-count helpers for the polynomial register bank transfer sequencer.
package poly_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_ISSUE = 2'd1,
        ST_LOAD_DRAIN = 2'd2,
        ST_STORE      = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] SEL_A   = 2'd0;
    localparam logic [1:0] SEL_B   = 2'd1;
    localparam logic [1:0] SEL_M   = 2'd2;
    localparam logic [1:0] SEL_MP0 = 2'd3;

    function automatic int load_words(input int n, input int s);
        return 3 * n * s + n;
    endfunction

    function automatic int store_words(input int n, input int s);
        return n * s;
    endfunction

    // Operand layout in BRAM: A, B, M (N*S words each) followed by N words of M_prime_0.
    function automatic logic [1:0] word_sel(input int k, input int n, input int s);
        if (k < n * s)
            return SEL_A;
        else if (k < 2 * n * s)
            return SEL_B;
        else if (k < 3 * n * s)
            return SEL_M;
        return SEL_MP0;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Delay line of {valid, sel} matching the BRAM read latency; sel holds its last valid value.
module bram_rd_pipe #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_i,
    input  logic [1:0] sel_i,
    output logic       valid_o,
    output logic [1:0] sel_o,
    output logic       pending_o
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic       vld_in, vld_d, vld_q;
        logic       pend_in, pend_w;
        logic [1:0] sel_in, sel_d, sel_q;

        if (gi == 0) begin : g_head
            assign vld_in  = valid_i;
            assign sel_in  = sel_i;
            assign pend_in = 1'b0;
        end else begin : g_link
            assign vld_in  = g_stage[gi-1].vld_q;
            assign sel_in  = g_stage[gi-1].sel_q;
            assign pend_in = g_stage[gi-1].pend_w;
        end

        // The output stage is excluded: pending means "more data still to arrive after this cycle".
        assign pend_w = pend_in | ((gi < DEPTH - 1) ? vld_q : 1'b0);

        always_comb begin
            vld_d = vld_in;
            sel_d = vld_in ? sel_in : sel_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                sel_q <= 2'd0;
            end else begin
                vld_q <= vld_d;
                sel_q <= sel_d;
            end
        end
    end

    assign valid_o   = g_stage[DEPTH-1].vld_q;
    assign sel_o     = g_stage[DEPTH-1].sel_q;
    assign pending_o = g_stage[DEPTH-1].pend_w;

endmodule

// File: rtl/poly_reg_bank_ctrl.sv
// Load/store sequencer between the MM controller and the POLY_reg_bank / operand BRAM pair.
module poly_reg_bank_ctrl
    import poly_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH   = 17,
    parameter int N            = 5,
    parameter int S            = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_load_i,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  bram_en_o,
    output logic                  bram_we_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [1:0]            INPUT_reg_sel_o,
    output logic                  INPUT_reg_en_o,
    output logic                  store_RES_reg_en_o
);

    localparam int LOAD_W  = load_words(N, S);
    localparam int STORE_W = store_words(N, S);
    localparam int CNT_W   = $clog2(LOAD_W + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_W);
    localparam logic [CNT_W-1:0] STORE_LAST = CNT_W'(STORE_W);

    if (BRAM_LATENCY < 1 || WORD_WIDTH < 1) begin : g_bad_param
        $error("poly_reg_bank_ctrl: BRAM_LATENCY and WORD_WIDTH must be >= 1");
    end

    ctrl_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  bram_en_q, bram_en_d;
    logic                  bram_we_q, bram_we_d;
    logic                  store_en_q, store_en_d;
    logic [1:0]            rd_sel_q, rd_sel_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  pipe_pending;

    // cnt_q counts words already issued; it doubles as the index of the next word.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_sel_d   = rd_sel_q;
        bram_en_d  = 1'b0;
        bram_we_d  = 1'b0;
        store_en_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    addr_d = cmd_base_addr_i;
                    cnt_d  = CNT_W'(1);
                    if (cmd_load_i) begin
                        state_d   = ST_LOAD_ISSUE;
                        bram_en_d = 1'b1;
                        rd_sel_d  = word_sel(0, N, S);
                    end else begin
                        state_d    = ST_STORE;
                        bram_we_d  = 1'b1;
                        store_en_d = 1'b1;
                    end
                end
            end
            ST_LOAD_ISSUE: begin
                if (cnt_q < LOAD_LAST) begin
                    bram_en_d = 1'b1;
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    rd_sel_d  = word_sel(int'(cnt_q), N, S);
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_LOAD_DRAIN;
                end
            end
            ST_LOAD_DRAIN: begin
                if (!pipe_pending) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_STORE: begin
                if (cnt_q < STORE_LAST) begin
                    bram_we_d  = 1'b1;
                    store_en_d = 1'b1;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    cnt_d      = cnt_q + CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rd_sel_q   <= SEL_A;
            bram_en_q  <= 1'b0;
            bram_we_q  <= 1'b0;
            store_en_q <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rd_sel_q   <= rd_sel_d;
            bram_en_q  <= bram_en_d;
            bram_we_q  <= bram_we_d;
            store_en_q <= store_en_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    bram_rd_pipe #(
        .DEPTH(BRAM_LATENCY)
    ) u_rd_pipe (
        .clk      (clock_i),
        .rst_n    (reset_n_i),
        .valid_i  (bram_en_q),
        .sel_i    (rd_sel_q),
        .valid_o  (INPUT_reg_en_o),
        .sel_o    (INPUT_reg_sel_o),
        .pending_o(pipe_pending)
    );

    assign cmd_ready_o        = ready_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign bram_en_o          = bram_en_q;
    assign bram_we_o          = bram_we_q;
    assign bram_addr_o        = addr_q;
    assign store_RES_reg_en_o = store_en_q;

endmodule

// File: tb/tb_poly_reg_bank_ctrl.sv
// Three sequencers (BRAM latency 1, 2, 4) share one stimulus stream; each is checked every cycle
// against a command-offset model, plus literal checks of the directed scenarios.
module tb_poly_reg_bank_ctrl;

    localparam int AW = 10;
    localparam int N  = 5;
    localparam int S  = 4;
    localparam int NS = N * S;
    localparam int LW = 3 * NS + N;
    localparam int SW = NS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_load;
    logic [AW-1:0] cmd_base;
    logic          stat_clr;
    int            cycle = 0;
    int            cmd_cyc = 0;
    int            checks = 0;
    int            passes = 0;
    event          ev_load, ev_store, ev_rst, ev_b2b, ev_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [1:0] sel_of(input int k);
        if (k < NS) return 2'd0;
        if (k < 2 * NS) return 2'd1;
        if (k < 3 * NS) return 2'd2;
        return 2'd3;
    endfunction

    task automatic check(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s (L=%0d, cycle %0d): got 0x%0h, expected 0x%0h", name, lat, cycle, act, exp);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        localparam int L        = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
        localparam int LIT_DONE = (gi == 0) ? 67 : (gi == 1) ? 68 : 70;

        logic          ready, busy, done, ben, bwe, inen, sten;
        logic [AW-1:0] addr;
        logic [1:0]    sel;

        poly_reg_bank_ctrl #(
            .WORD_WIDTH(17), .N(N), .S(S), .ADDR_WIDTH(AW), .BRAM_LATENCY(L)
        ) u_dut (
            .clock_i           (clk),
            .reset_n_i         (rst_n),
            .cmd_valid_i       (cmd_valid),
            .cmd_ready_o       (ready),
            .cmd_load_i        (cmd_load),
            .cmd_base_addr_i   (cmd_base),
            .busy_o            (busy),
            .done_o            (done),
            .bram_en_o         (ben),
            .bram_we_o         (bwe),
            .bram_addr_o       (addr),
            .INPUT_reg_sel_o   (sel),
            .INPUT_reg_en_o    (inen),
            .store_RES_reg_en_o(sten)
        );

        // Model: m_d = cycles since acceptance of the current command (1 = first cycle after accept).
        bit            m_act, m_load;
        int            m_d;
        logic [AW-1:0] m_base, m_addr_hold;
        logic [1:0]    m_sel_hold;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_act = 1'b0; m_d = 0; m_addr_hold = '0; m_sel_hold = 2'd0;
            end else begin
                bit rdy;
                int endd;
                endd = m_load ? LW + L + 1 : SW + 1;
                rdy  = !m_act || (m_d == endd);
                if (m_act && m_d == endd) begin
                    m_addr_hold = m_base + AW'(m_load ? LW - 1 : SW - 1);
                    if (m_load) m_sel_hold = 2'd3;
                    m_act = 1'b0;
                end
                if (cmd_valid && rdy) begin
                    m_act = 1'b1; m_load = cmd_load; m_base = cmd_base; m_d = 1;
                end else if (m_act) begin
                    m_d++;
                end
            end
        end

        int            en_cnt, we_cnt, in_cnt, done_cnt, done_cyc, first_in_cyc, first_we_cyc;
        int            sel_pulse [4];
        logic [AW-1:0] wr_first, wr_9, wr_last;

        always @(negedge clk) begin
            logic          e_rdy, e_busy, e_done, e_en, e_we, e_in;
            logic [AW-1:0] e_addr;
            logic [1:0]    e_sel;
            int            endd, nw, k;
            e_rdy = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0; e_we = 1'b0; e_in = 1'b0;
            e_addr = m_addr_hold; e_sel = m_sel_hold;
            if (rst_n && m_act) begin
                endd   = m_load ? LW + L + 1 : SW + 1;
                nw     = m_load ? LW : SW;
                e_rdy  = (m_d == endd);
                e_busy = !e_rdy;
                e_done = e_rdy;
                k      = (m_d <= nw) ? m_d - 1 : nw - 1;
                e_addr = m_base + AW'(k);
                if (m_load) begin
                    e_en = (m_d <= LW);
                    e_in = (m_d >= L + 1) && (m_d <= LW + L);
                    if (m_d >= L + 1) e_sel = sel_of((m_d - L - 1 < LW) ? m_d - L - 1 : LW - 1);
                end else begin
                    e_we = (m_d <= SW);
                end
            end
            check("cmd_ready", L, 32'(ready), 32'(e_rdy));
            check("busy", L, 32'(busy), 32'(e_busy));
            check("done", L, 32'(done), 32'(e_done));
            check("bram_en", L, 32'(ben), 32'(e_en));
            check("bram_we", L, 32'(bwe), 32'(e_we));
            check("store_RES_en", L, 32'(sten), 32'(e_we));
            check("bram_addr", L, 32'(addr), 32'(e_addr));
            check("INPUT_en", L, 32'(inen), 32'(e_in));
            check("INPUT_sel", L, 32'(sel), 32'(e_sel));

            if (stat_clr) begin
                en_cnt = 0; we_cnt = 0; in_cnt = 0; done_cnt = 0;
                done_cyc = -1; first_in_cyc = -1; first_we_cyc = -1;
                for (int i = 0; i < 4; i++) sel_pulse[i] = 0;
            end
            if (ben) en_cnt++;
            if (inen) begin
                in_cnt++;
                if (first_in_cyc < 0) first_in_cyc = cycle;
                if (sel_pulse[sel] == 0) sel_pulse[sel] = in_cnt;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cycle;
            end
            if (bwe) begin
                we_cnt++;
                if (first_we_cyc < 0) begin first_we_cyc = cycle; wr_first = addr; end
                if (we_cnt == 9) wr_9 = addr;
                wr_last = addr;
            end
        end

        initial begin
            @(ev_load);
            check("load_reads", L, en_cnt, 65);
            check("load_in_pulses", L, in_cnt, 65);
            check("load_first_in_ofs", L, first_in_cyc - cmd_cyc, L + 1);
            check("load_done_ofs", L, done_cyc - cmd_cyc, LIT_DONE);
            check("load_done_cnt", L, done_cnt, 1);
            check("sel_A_pulse", L, sel_pulse[0], 1);
            check("sel_B_pulse", L, sel_pulse[1], 21);
            check("sel_M_pulse", L, sel_pulse[2], 41);
            check("sel_MP0_pulse", L, sel_pulse[3], 61);
            @(ev_store);
            check("store_writes", L, we_cnt, 20);
            check("store_first_addr", L, 32'(wr_first), 32'h3F8);
            check("store_wrap_addr", L, 32'(wr_9), 32'h000);
            check("store_last_addr", L, 32'(wr_last), 32'h00B);
            check("store_done_ofs", L, done_cyc - cmd_cyc, 21);
            check("store_reads", L, en_cnt, 0);
            @(ev_rst);
            check("rst_in_pulses", L, in_cnt, 0);
            check("rst_done_cnt", L, done_cnt, 0);
            check("rst_ready", L, 32'(ready), 32'h1);
            @(ev_b2b);
            check("b2b_done_cnt", L, done_cnt, 2);
            check("b2b_writes", L, we_cnt, 20);
            check("b2b_gap", L, first_we_cyc - done_cyc, 1);
            check("b2b_first_we_ofs", L, first_we_cyc - cmd_cyc, LIT_DONE + 1);
            @(ev_busy);
            check("busy_done_cnt", L, done_cnt, 1);
            check("busy_writes", L, we_cnt, 20);
            check("busy_reads", L, en_cnt, 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic load, input logic [AW-1:0] base);
        cmd_valid = 1'b1; cmd_load = load; cmd_base = base; stat_clr = 1'b1; cmd_cyc = cycle;
        step(1);
        cmd_valid = 1'b0; stat_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_base = '0; stat_clr = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);

        issue(1'b1, 10'h100);
        step(80);
        ->ev_load; #1;

        issue(1'b0, 10'h3F8);
        step(25);
        ->ev_store; #1;

        issue(1'b1, 10'h040);
        step(29);
        #2 rst_n = 1'b0;
        step(1);
        rst_n = 1'b1; stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        step(80);
        ->ev_rst; #1;

        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_base = 10'h200; stat_clr = 1'b1; cmd_cyc = cycle;
        step(1);
        stat_clr = 1'b0; cmd_load = 1'b0; cmd_base = 10'h300;
        step(75);
        cmd_valid = 1'b0;
        step(30);
        ->ev_b2b; #1;

        issue(1'b0, 10'h055);
        step(5);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_base = 10'h111;
        step(3);
        cmd_valid = 1'b0;
        step(25);
        ->ev_busy; #1;

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_load  = 1'($urandom_range(0, 1));
            cmd_base  = AW'($urandom);
            step(1);
        end
        cmd_valid = 1'b0;
        step(100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
